// File: rtl/aes_key_expand_if.sv
// Bus between the AES key-schedule stage and the cipher cores that consume its round keys.
// Groups the start/key request and the combinational round-key read port.
interface aes_key_expand_if;
    // start is a level sampled on every rising clk and has no ready partner.
    // It is accepted only in IDLE or DONE with key_len != 0; busy rises on that edge.
    // key_ready marks the whole store valid, and subkey_valid qualifies each combinational read.
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key;
    logic         busy;
    logic         key_ready;
    logic [3:0]   subkey_addr;
    logic [127:0] subkey;
    logic         subkey_valid;

    modport master (
        output start, key_len, key, subkey_addr,
        input  busy, key_ready, subkey, subkey_valid
    );

    modport slave (
        input  start, key_len, key, subkey_addr,
        output busy, key_ready, subkey, subkey_valid
    );
endinterface

// File: rtl/aes_key_expand.sv
// Iterative AES-128/192/256 key expansion, one 32-bit word per cycle, into a 60-word store.
// Round keys are read combinationally by index and masked to zero until the store is complete.
module aes_key_expand #(
    parameter int MAX_WORDS = 60
) (
    input  logic              clk,
    input  logic              reset,
    aes_key_expand_if.slave   bus,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Forward S-box, byte 0x00 in the top 8 bits.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    state_t       state;
    logic [31:0]  w [MAX_WORDS];
    logic [5:0]   i;
    logic [5:0]   total;
    logic [3:0]   nk;
    logic [3:0]   nr;
    logic [2:0]   j;
    logic [7:0]   rcon;
    logic         busy_r;
    logic         key_ready_r;

    logic         accept;
    logic [3:0]   nk_new;
    logic [3:0]   nr_new;
    logic [5:0]   total_new;
    logic [31:0]  prev_word;
    logic [31:0]  back_word;
    logic [31:0]  temp;
    logic [31:0]  new_word;
    logic [7:0]   rcon_next;
    logic         valid;
    logic [5:0]   base;

    assign accept = bus.start && (bus.key_len != 2'b00) && (state == IDLE || state == DONE);

    always_comb begin
        nk_new    = 4'd4;
        nr_new    = 4'd10;
        total_new = 6'd44;
        case (bus.key_len)
            2'b10: begin
                nk_new    = 4'd6;
                nr_new    = 4'd12;
                total_new = 6'd52;
            end
            2'b11: begin
                nk_new    = 4'd8;
                nr_new    = 4'd14;
                total_new = 6'd60;
            end
            default: ;
        endcase
    end

    // j tracks i mod Nk incrementally, so no divider is needed to find the rcon/SubWord slots.
    assign prev_word = w[i - 6'd1];
    assign back_word = w[i - {2'b00, nk}];

    always_comb begin
        temp = prev_word;
        if (j == 3'd0) begin
            temp = sub_word({prev_word[23:0], prev_word[31:24]}) ^ {rcon, 24'h000000};
        end else if (nk == 4'd8 && j == 3'd4) begin
            temp = sub_word(prev_word);
        end
    end

    assign new_word  = back_word ^ temp;
    assign rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

    // The store is not reset; key_ready masks its contents from the read port.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < 8; k++) begin
                w[k] <= bus.key[255 - 32*k -: 32];
            end
        end else if (state == EXPAND) begin
            w[i] <= new_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            busy_r      <= 1'b0;
            key_ready_r <= 1'b0;
            i           <= 6'd0;
            j           <= 3'd0;
            nk          <= 4'd0;
            nr          <= 4'd0;
            total       <= 6'd0;
            rcon        <= 8'h01;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        nk          <= nk_new;
                        nr          <= nr_new;
                        total       <= total_new;
                        i           <= {2'b00, nk_new};
                        j           <= 3'd0;
                        rcon        <= 8'h01;
                        key_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        state       <= EXPAND;
                    end
                end
                EXPAND: begin
                    i <= i + 6'd1;
                    if ({1'b0, j} == nk - 4'd1) begin
                        j    <= 3'd0;
                        rcon <= rcon_next;
                    end else begin
                        j <= j + 3'd1;
                    end
                    if (i == total - 6'd1) begin
                        busy_r      <= 1'b0;
                        key_ready_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign valid = key_ready_r && (bus.subkey_addr <= nr);
    assign base  = {bus.subkey_addr, 2'b00};

    assign bus.busy         = busy_r;
    assign bus.key_ready    = key_ready_r;
    assign bus.subkey_valid = valid;
    assign bus.subkey       = valid ? {w[base], w[base | 6'd1], w[base | 6'd2], w[base | 6'd3]}
                                    : 128'h0;
    assign state_dbg        = state;

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand: FIPS-197 key schedules, restart/ignore cases, async reset.
// Expected round keys are queued when a start is driven and popped as each read is made.
module tb_aes_key_expand;

    logic       clk;
    logic       reset;
    logic [1:0] state_dbg;
    int         checks;
    int         errors;
    int         cyc;
    logic [127:0] exp_q[$];

    localparam logic [255:0] K128_A = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K128_B = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K192   = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256   =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    // FIPS-197 C.1 round keys for K128_B, index = round.
    localparam logic [127:0] RK_B [11] = '{
        128'h000102030405060708090a0b0c0d0e0f,
        128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'hb692cf0b643dbdf1be9bc5006830b3fe,
        128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'h47f7f7bc95353e03f96c32bcfd058dfd,
        128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h5e390f7df7a69296a7553dc10aa31f6b,
        128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h47438735a41c65b9e016baf4aebf7ad2,
        128'h549932d1f08557681093ed9cbe2c974e,
        128'h13111d7fe3944a17f307a78b4d2b30c5
    };

    aes_key_expand_if bus ();

    aes_key_expand #(.MAX_WORDS(60)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [1:0] len, input logic [255:0] k);
        bus.start   = 1'b1;
        bus.key_len = len;
        bus.key     = k;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.key_len = 2'($urandom_range(0, 3));
        bus.key     = {$urandom(), $urandom(), $urandom(), $urandom(),
                       $urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!bus.key_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic read_key(input logic [3:0] addr, input string tag);
        logic [127:0] e;
        bus.subkey_addr = addr;
        #1;
        if (exp_q.size() == 0) begin
            e = 128'hx;
        end else begin
            e = exp_q.pop_front();
        end
        check({tag, "_valid"}, {127'h0, bus.subkey_valid}, 128'h1);
        check(tag, bus.subkey, e);
        @(posedge clk);
        #1;
    endtask

    task automatic read_invalid(input logic [3:0] addr, input string tag);
        bus.subkey_addr = addr;
        #1;
        check({tag, "_valid"}, {127'h0, bus.subkey_valid}, 128'h0);
        check(tag, bus.subkey, 128'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.key_len     = 2'b00;
        bus.key         = '0;
        bus.subkey_addr = 4'd0;
        #1;
        check("rst_busy", {127'h0, bus.busy}, 128'h0);
        check("rst_ready", {127'h0, bus.key_ready}, 128'h0);
        check("rst_valid", {127'h0, bus.subkey_valid}, 128'h0);
        check("rst_subkey", bus.subkey, 128'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // AES-128 FIPS-197 A.1 key.
        exp_q.push_back(128'h2b7e151628aed2a6abf7158809cf4f3c);
        exp_q.push_back(128'ha0fafe1788542cb123a339392a6c7605);
        exp_q.push_back(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        do_start(2'b01, K128_A);
        check("a128_busy", {127'h0, bus.busy}, 128'h1);
        check("a128_notready", {127'h0, bus.key_ready}, 128'h0);
        wait_ready(cyc);
        check("a128_latency", 128'(cyc), 128'd40);
        check("a128_busy_done", {127'h0, bus.busy}, 128'h0);
        read_key(4'd0, "a128_rk0");
        read_key(4'd1, "a128_rk1");
        read_key(4'd10, "a128_rk10");
        read_invalid(4'd11, "a128_rk11");
        read_invalid(4'd15, "a128_rk15");

        // key_len=00 in DONE changes nothing.
        exp_q.push_back(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        bus.start   = 1'b1;
        bus.key_len = 2'b00;
        bus.key     = K256;
        repeat (3) @(posedge clk);
        #1;
        check("len0_busy", {127'h0, bus.busy}, 128'h0);
        check("len0_ready", {127'h0, bus.key_ready}, 128'h1);
        bus.start = 1'b0;
        read_key(4'd10, "len0_rk10");

        // AES-192 FIPS-197 A.2 key, restarting from DONE.
        exp_q.push_back(128'h8e73b0f7da0e6452c810f32b809079e5);
        exp_q.push_back(128'he98ba06f448c773c8ecc720401002202);
        do_start(2'b10, K192);
        check("a192_drop_ready", {127'h0, bus.key_ready}, 128'h0);
        check("a192_drop_valid", {127'h0, bus.subkey_valid}, 128'h0);
        wait_ready(cyc);
        check("a192_latency", 128'(cyc), 128'd46);
        read_key(4'd0, "a192_rk0");
        read_key(4'd12, "a192_rk12");
        read_invalid(4'd13, "a192_rk13");

        // AES-256 FIPS-197 A.3 key; round 14 depends on the j==4 SubWord path.
        exp_q.push_back(128'h603deb1015ca71be2b73aef0857d7781);
        exp_q.push_back(128'h1f352c073b6108d72d9810a30914dff4);
        exp_q.push_back(128'hfe4890d1e6188d0b046df344706c631e);
        do_start(2'b11, K256);
        wait_ready(cyc);
        check("a256_latency", 128'(cyc), 128'd52);
        read_key(4'd0, "a256_rk0");
        read_key(4'd1, "a256_rk1");
        read_key(4'd14, "a256_rk14");
        read_invalid(4'd15, "a256_rk15");

        // Decrypt-order sweep, with an ignored start pulse mid-expansion.
        for (int r = 10; r >= 0; r--) exp_q.push_back(RK_B[r]);
        do_start(2'b01, K128_B);
        repeat (10) @(posedge clk);
        #1;
        bus.start   = 1'b1;
        bus.key_len = 2'b11;
        bus.key     = K256;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("mid_busy", {127'h0, bus.busy}, 128'h1);
        wait_ready(cyc);
        check("mid_latency", 128'(cyc), 128'd29);
        for (int r = 10; r >= 0; r--) read_key(4'(r), $sformatf("sweep_rk%0d", r));

        // Async reset mid-expansion, between clock edges.
        do_start(2'b11, K256);
        repeat (19) @(posedge clk);
        #1;
        check("ar_busy_before", {127'h0, bus.busy}, 128'h1);
        bus.subkey_addr = 4'd0;
        #2;
        reset = 1'b1;
        #1;
        check("ar_busy", {127'h0, bus.busy}, 128'h0);
        check("ar_ready", {127'h0, bus.key_ready}, 128'h0);
        check("ar_valid", {127'h0, bus.subkey_valid}, 128'h0);
        check("ar_subkey", bus.subkey, 128'h0);

        // start with reset held: reset wins.
        bus.start   = 1'b1;
        bus.key_len = 2'b01;
        bus.key     = K128_A;
        @(posedge clk);
        #1;
        check("rst_start_busy", {127'h0, bus.busy}, 128'h0);
        bus.start = 1'b0;
        reset     = 1'b0;
        @(posedge clk);
        #1;

        exp_q.push_back(128'ha0fafe1788542cb123a339392a6c7605);
        exp_q.push_back(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        do_start(2'b01, K128_A);
        wait_ready(cyc);
        check("post_rst_latency", 128'(cyc), 128'd40);
        read_key(4'd1, "post_rst_rk1");
        read_key(4'd10, "post_rst_rk10");

        check("queue_empty", 128'(exp_q.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Key-schedule stage directly upstream of the AES decryption core.
- Accepts a 128/192/256-bit cipher key and expands it iteratively, one 32-bit word per cycle, into an internal round-key store (up to 15 x 128 bits).
- Serves the core's round-key requests: combinational read by subkey_addr, qualified by subkey_valid.
- The same store serves the encryption core, which reads ascending addresses.

Parameters:
- MAX_WORDS, 60, depth of the word store (4*(14+1)); fixed for AES-256 worst case.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin expansion of key; sampled on rising clk.
- key_len  input  2  01=AES-128, 10=AES-192, 11=AES-256, 00=invalid (start ignored).
- key  input  256  cipher key, left-aligned: 128-bit uses key[255:128], 192-bit uses key[255:64]; word w0 = key[255:224].
- busy  output  1  expansion in progress.
- key_ready  output  1  round-key store complete and valid.
- subkey_addr  input  4  round-key index requested (0..Nr).
- subkey  output  128  round key {w[4a], w[4a+1], w[4a+2], w[4a+3]}, a = subkey_addr; w[4a] in [127:96].
- subkey_valid  output  1  key_ready AND subkey_addr <= Nr.

Behaviour:
- Derived constants, latched at start:
  - Nk = 4/6/8; Nr = 10/12/14; total words T = 44/52/60.
- FSM states:
  - IDLE: reset state.
  - EXPAND: busy=1, key_ready=0.
  - DONE: key_ready=1.
- Start acceptance:
  - start=1 with key_len!=00 in IDLE or DONE is accepted on that edge.
  - On that edge: w[0..Nk-1] load from key, Nk/Nr latch, word counter i=Nk, position counter j=0, rcon=8'h01, key_ready->0, busy->1, state->EXPAND.
  - key and key_len are sampled only on the accepting edge; later changes are ignored.
- EXPAND, one word per cycle:
  - temp = w[i-1].
  - If j==0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}.
  - Else if Nk==8 and j==4: temp = SubWord(temp).
  - w[i] <= w[i-Nk] ^ temp.
  - i increments. j wraps at Nk-1 -> 0. On each wrap, rcon <= xtime(rcon), giving 01,02,04,08,10,20,40,80,1B,36.
  - No modulo or divide hardware.
- SubWord: four forward S-box lookups (same forward S-box logic as the encryption core); purely combinational within the cycle.
- Completion:
  - On the edge writing w[T-1]: state->DONE, busy->0, key_ready->1.
  - key_ready rises exactly T-Nk edges after the accepting edge: 40 (128-bit), 46 (192-bit), 52 (256-bit).
- Read port:
  - Combinational, zero latency: subkey tracks subkey_addr in the same cycle.
  - subkey = 0 whenever subkey_valid=0.
  - subkey_addr > Nr gives subkey_valid=0 and subkey=0. Example: 11..15 in AES-128 mode, 15 in AES-256 mode.
- Boundary conditions:
  - start during EXPAND: ignored; expansion continues unaffected.
  - start with key_len=00: ignored in every state; outputs unchanged.
  - start in DONE: restart. key_ready drops on the accepting edge; old keys are no longer readable.
  - start and reset together: reset wins.
- Reset:
  - Asynchronous assertion, at any time including mid-expansion.
  - Effects: state=IDLE, busy=0, key_ready=0, subkey_valid=0, subkey=0, counters=0, rcon=01.
  - Word store contents need not be cleared; they are masked by key_ready.
- Downstream contract: the core may hold start until subkey_valid; no further handshake exists.

Test Plan:
- AES-128, key=2b7e151628aed2a6abf7158809cf4f3c, start 1 cycle -> busy=1 for 40 cycles, then key_ready=1. Reads: addr 0 = key; addr 1 = a0fafe1788542cb123a339392a6c7605; addr 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; addr 11 -> subkey_valid=0, subkey=0.
- AES-192, key=8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b (left-aligned) -> key_ready after 46 cycles; addr 12 = e98ba06f448c773c8ecc720401002202.
- AES-256, key=603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> key_ready after 52 cycles; addr 14 = fe4890d1e6188d0b046df344706c631e. Exercises the j==4 SubWord path.
- Decrypt-order reads: key 000102030405060708090a0b0c0d0e0f (AES-128), sweep addr 10 down to 0 one per cycle -> subkey_valid=1 each cycle; addr 10 = 13111d7fe3944a17f307a78b4d2b30c5, same-cycle response.
- Restart and ignore cases:
  - start pulse mid-EXPAND with a different key -> ignored; final keys match the first key.
  - start with key_len=00 in DONE -> no change.
  - new valid start in DONE -> key_ready drops the next edge and the new key schedule appears after 40 cycles.
- Async reset asserted between clock edges at cycle 20 of expansion -> busy, key_ready, subkey_valid go to 0 immediately without waiting for a clock edge. A fresh start after deassertion completes correctly.
